// File: rtl/hamming_pkg.sv
// hamming_pkg: shared Hamming geometry helpers (parity width, code width, bit placement).
// Latency: n/a (constant functions only).
// Backpressure: n/a.
// Macro HAMMING_SECDED_EN adds the overall even-parity bit to the code width.
package hamming_pkg;

  // Smallest r with 2^r >= data_w + r + 1.
  function automatic int calc_par_w(input int data_w);
    int r;
    r = 0;
    for (int i = 7; i >= 1; i--) begin
      if ((1 << i) >= data_w + i + 1) r = i;
    end
    return r;
  endfunction

  // Number of Hamming positions (data + parity, excluding the overall bit).
  function automatic int calc_n(input int data_w);
    return data_w + calc_par_w(data_w);
  endfunction

  // Width of the received codeword.
  function automatic int calc_code_w(input int data_w);
`ifdef HAMMING_SECDED_EN
    return calc_n(data_w) + 1;
`else
    return calc_n(data_w);
`endif
  endfunction

  // Position k (1-based) -> data bit index, or -1 when k holds a parity bit.
  // Data index = positions below k minus the powers of two below k.
  function automatic int pos_para_idx(input int k);
    int idx;
    if ((k & (k - 1)) == 0) return -1;
    idx = k - 1;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) < k) idx = idx - 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/hamming_sindrome.sv
// hamming_sindrome: combinational syndrome and overall parity of one codeword.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller registers the result.
// Ports: codigo (CODE_W) in; sindrome (PAR_W) and paridade (XOR of all CODE_W bits) out.
module hamming_sindrome
  import hamming_pkg::*;
#(
  parameter int DATA_W = 11,
  localparam int PAR_W = calc_par_w(DATA_W),
  localparam int N = calc_n(DATA_W),
  localparam int CODE_W = calc_code_w(DATA_W)
) (
  input  logic [CODE_W-1:0] codigo,
  output logic [PAR_W-1:0]  sindrome,
  output logic              paridade
);

  // XOR-ing the position numbers of all set bits yields every syndrome bit at once.
  always_comb begin
    sindrome = '0;
    for (int k = 1; k <= N; k++) begin
      if (codigo[k-1]) sindrome = sindrome ^ PAR_W'(k);
    end
    paridade = ^codigo;
  end

endmodule

// File: rtl/corrige_hamming_stream.sv
// corrige_hamming_stream: streaming Hamming decoder with single-error correction and error counters.
// Latency: 2 cycles (stage 1 = word+syndrome, stage 2 = corrected data+flags) with saida_ready high.
// Backpressure: valid/ready; entrada_ready drops only when both stages are full and saida_ready is low.
// Ports: clk, rst (async, active-high); entrada/entrada_valid/entrada_ready upstream;
//        saida/saida_valid/saida_ready, erro_corrigido, erro_duplo, sindrome downstream;
//        limpa_cnt clears cnt_corrigido/cnt_duplo. Macro HAMMING_SECDED_EN enables SECDED.
module corrige_hamming_stream
  import hamming_pkg::*;
#(
  parameter int DATA_W = 11,
  parameter int CNT_W = 16,
  localparam int PAR_W = calc_par_w(DATA_W),
  localparam int N = calc_n(DATA_W),
  localparam int CODE_W = calc_code_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] entrada,
  input  logic              entrada_valid,
  output logic              entrada_ready,
  output logic [DATA_W-1:0] saida,
  output logic              saida_valid,
  input  logic              saida_ready,
  output logic              erro_corrigido,
  output logic              erro_duplo,
  output logic [PAR_W-1:0]  sindrome,
  input  logic              limpa_cnt,
  output logic [CNT_W-1:0]  cnt_corrigido,
  output logic [CNT_W-1:0]  cnt_duplo
);

  localparam logic [PAR_W-1:0] N_L = PAR_W'(N);

  // Stage 1 keeps only the N Hamming positions; the overall bit is folded into s1_par.
  logic              s1_vld_q, s1_vld_d;
  logic [N-1:0]      s1_cod_q, s1_cod_d;
  logic [PAR_W-1:0]  s1_sind_q, s1_sind_d;
  logic              s1_par_q, s1_par_d;
  logic              s2_vld_q, s2_vld_d;
  logic [DATA_W-1:0] saida_q, saida_d;
  logic              corr_q, corr_d;
  logic              duplo_q, duplo_d;
  logic [PAR_W-1:0]  sind_q, sind_d;
  logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0]  cnt_dup_q, cnt_dup_d;

  logic [PAR_W-1:0]  sind_c;
  logic              par_c;
  logic              s2_livre;
  logic              flip_en;
  logic              corr_c;
  logic              duplo_c;
  logic [N-1:0]      cod_fix;
  logic [DATA_W-1:0] dado_c;

  hamming_sindrome #(.DATA_W(DATA_W)) u_sindrome (
    .codigo   (entrada),
    .sindrome (sind_c),
    .paridade (par_c)
  );

  assign s2_livre      = ~s2_vld_q | saida_ready;
  assign entrada_ready = saida_ready | ~s2_vld_q | ~s1_vld_q;

  // Classify the stage-1 word and flip the indicated position.
  always_comb begin
    corr_c  = 1'b0;
    duplo_c = 1'b0;
    flip_en = 1'b0;
`ifdef HAMMING_SECDED_EN
    if (s1_sind_q == '0) begin
      // Only the overall parity bit is wrong: data already correct.
      corr_c = s1_par_q;
    end else if (s1_par_q && (s1_sind_q <= N_L)) begin
      corr_c  = 1'b1;
      flip_en = 1'b1;
    end else begin
      duplo_c = 1'b1;
    end
`else
    if (s1_sind_q == '0) begin
      corr_c = 1'b0;
    end else if (s1_sind_q <= N_L) begin
      corr_c  = 1'b1;
      flip_en = 1'b1;
    end else begin
      duplo_c = 1'b1;
    end
`endif
    cod_fix = s1_cod_q;
    if (flip_en) cod_fix = s1_cod_q ^ (N'(1) << (s1_sind_q - 1'b1));
  end

  // Gather data bits from the non-power-of-two positions.
  for (genvar k = 1; k <= N; k++) begin : g_ext
    if (pos_para_idx(k) >= 0) begin : g_dado
      assign dado_c[pos_para_idx(k)] = cod_fix[k-1];
    end
  end

  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_cod_d   = s1_cod_q;
    s1_sind_d  = s1_sind_q;
    s1_par_d   = s1_par_q;
    s2_vld_d   = s2_vld_q;
    saida_d    = saida_q;
    corr_d     = corr_q;
    duplo_d    = duplo_q;
    sind_d     = sind_q;
    cnt_corr_d = cnt_corr_q;
    cnt_dup_d  = cnt_dup_q;

    if (entrada_ready) begin
      s1_vld_d = entrada_valid;
      if (entrada_valid) begin
        s1_cod_d  = entrada[N-1:0];
        s1_sind_d = sind_c;
        s1_par_d  = par_c;
      end
    end

    // Stage 2 only changes when empty or being drained, so outputs hold while stalled.
    if (s2_livre) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        saida_d = dado_c;
        corr_d  = corr_c;
        duplo_d = duplo_c;
        sind_d  = s1_sind_q;
      end
    end

    if (limpa_cnt) begin
      cnt_corr_d = '0;
      cnt_dup_d  = '0;
    end else if (s2_vld_q && saida_ready) begin
      if (corr_q && (cnt_corr_q != {CNT_W{1'b1}})) cnt_corr_d = cnt_corr_q + CNT_W'(1);
      if (duplo_q && (cnt_dup_q != {CNT_W{1'b1}})) cnt_dup_d = cnt_dup_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_cod_q   <= '0;
      s1_sind_q  <= '0;
      s1_par_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      saida_q    <= '0;
      corr_q     <= 1'b0;
      duplo_q    <= 1'b0;
      sind_q     <= '0;
      cnt_corr_q <= '0;
      cnt_dup_q  <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_cod_q   <= s1_cod_d;
      s1_sind_q  <= s1_sind_d;
      s1_par_q   <= s1_par_d;
      s2_vld_q   <= s2_vld_d;
      saida_q    <= saida_d;
      corr_q     <= corr_d;
      duplo_q    <= duplo_d;
      sind_q     <= sind_d;
      cnt_corr_q <= cnt_corr_d;
      cnt_dup_q  <= cnt_dup_d;
    end
  end

  assign saida          = saida_q;
  assign saida_valid    = s2_vld_q;
  assign erro_corrigido = corr_q;
  assign erro_duplo     = duplo_q;
  assign sindrome       = sind_q;
  assign cnt_corrigido  = cnt_corr_q;
  assign cnt_duplo      = cnt_dup_q;

endmodule

// File: tb/tb_corrige_hamming_stream.sv
// tb_corrige_hamming_stream: directed plus randomized checks of corrige_hamming_stream.
// Expected words come from an encoder/error-injection model; counters from a saturating model.
// Builds with or without HAMMING_SECDED_EN.
module tb_corrige_hamming_stream;

  localparam int DATA_W = 11;
  localparam int CNT_W  = 4;
  localparam int PAR_W  = 4;
  localparam int N      = 15;
`ifdef HAMMING_SECDED_EN
  localparam int CODE_W = 16;
  localparam bit SECDED = 1'b1;
`else
  localparam int CODE_W = 15;
  localparam bit SECDED = 1'b0;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] dado;
    logic              corr;
    logic              duplo;
    logic [PAR_W-1:0]  sind;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [CODE_W-1:0] entrada;
  logic              entrada_valid;
  logic              entrada_ready;
  logic [DATA_W-1:0] saida;
  logic              saida_valid;
  logic              saida_ready;
  logic              erro_corrigido;
  logic              erro_duplo;
  logic [PAR_W-1:0]  sindrome;
  logic              limpa_cnt;
  logic [CNT_W-1:0]  cnt_corrigido;
  logic [CNT_W-1:0]  cnt_duplo;

  exp_t fila[$];
  exp_t pend;
  int   total, bad, n_out;
  int   m_corr, m_dup;
  int   stall_left;
  bit   rnd_ready;
  bit   last_in_fire, last_out_fire, last_sv, saw_block;

  corrige_hamming_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .entrada        (entrada),
    .entrada_valid  (entrada_valid),
    .entrada_ready  (entrada_ready),
    .saida          (saida),
    .saida_valid    (saida_valid),
    .saida_ready    (saida_ready),
    .erro_corrigido (erro_corrigido),
    .erro_duplo     (erro_duplo),
    .sindrome       (sindrome),
    .limpa_cnt      (limpa_cnt),
    .cnt_corrigido  (cnt_corrigido),
    .cnt_duplo      (cnt_duplo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: data at non-power-of-two positions, even parity at powers of two.
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] w;
    int j;
    logic p;
    w = '0;
    j = 0;
    for (int k = 1; k <= N; k++) begin
      if ((k & (k - 1)) != 0) begin
        w[k-1] = d[j];
        j++;
      end
    end
    for (int i = 0; i < PAR_W; i++) begin
      p = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if ((((k >> i) & 1) == 1) && (k != (1 << i))) p = p ^ w[k-1];
      end
      w[(1 << i) - 1] = p;
    end
`ifdef HAMMING_SECDED_EN
    w[CODE_W-1] = ^w[N-1:0];
`endif
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] w);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int k = 1; k <= N; k++) begin
      if ((k & (k - 1)) != 0) begin
        d[j] = w[k-1];
        j++;
      end
    end
    return d;
  endfunction

  // One clock: sample handshakes at negedge, score, then step past the posedge.
  task automatic cyc();
    @(negedge clk);
    last_in_fire  = entrada_valid && entrada_ready;
    last_out_fire = saida_valid && saida_ready;
    last_sv       = saida_valid;
    if (entrada_valid && !entrada_ready) saw_block = 1'b1;
    if (rst) begin
      fila.delete();
      m_corr = 0;
      m_dup  = 0;
    end
    chk("cnt_corrigido", cnt_corrigido, m_corr);
    chk("cnt_duplo", cnt_duplo, m_dup);
    if (!rst) begin
      if (saida_valid) begin
        if (fila.size() == 0) begin
          chk("spurious_word", saida_valid, 0);
        end else begin
          chk("saida", saida, fila[0].dado);
          chk("erro_corrigido", erro_corrigido, fila[0].corr);
          chk("erro_duplo", erro_duplo, fila[0].duplo);
          chk("sindrome", sindrome, fila[0].sind);
          if (saida_ready) begin
            if (fila[0].corr && m_corr < CNT_MAX) m_corr++;
            if (fila[0].duplo && m_dup < CNT_MAX) m_dup++;
            void'(fila.pop_front());
            n_out++;
          end
        end
      end
      if (limpa_cnt) begin
        m_corr = 0;
        m_dup  = 0;
      end
      if (last_in_fire) fila.push_back(pend);
    end
    @(posedge clk);
    #1;
    if (stall_left > 0) begin
      saida_ready = 1'b0;
      stall_left--;
    end else if (rnd_ready) begin
      saida_ready = 1'($urandom_range(0, 1));
    end else begin
      saida_ready = 1'b1;
    end
  endtask

  task automatic send(input logic [CODE_W-1:0] w, input exp_t e);
    int n;
    entrada       = w;
    entrada_valid = 1'b1;
    pend          = e;
    n             = 0;
    do begin
      cyc();
      n++;
    end while (!last_in_fire && n < 50);
    if (!last_in_fire) chk("send_timeout", last_in_fire, 1);
    entrada_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (fila.size() > 0 && n < 200) begin
      cyc();
      n++;
    end
    chk("drain_empty", fila.size(), 0);
  endtask

  // Random word: encode random data then flip 0, 1 (or 2 with SECDED) distinct positions.
  task automatic rand_word(input int nflip, output logic [CODE_W-1:0] w, output exp_t e);
    logic [DATA_W-1:0] d;
    int p1, p2;
    d = DATA_W'($urandom);
    w = encode(d);
    p1 = $urandom_range(1, CODE_W);
    do p2 = $urandom_range(1, CODE_W); while (p2 == p1);
    e.dado  = d;
    e.corr  = 1'b0;
    e.duplo = 1'b0;
    e.sind  = '0;
    if (nflip >= 1) begin
      w[p1-1] = ~w[p1-1];
      e.corr  = 1'b1;
      e.sind  = (p1 <= N) ? PAR_W'(p1) : '0;
    end
    if (nflip == 2) begin
      w[p2-1] = ~w[p2-1];
      e.corr  = 1'b0;
      e.duplo = 1'b1;
      e.sind  = e.sind ^ ((p2 <= N) ? PAR_W'(p2) : '0);
      e.dado  = extract(w);
    end
  endtask

  initial begin
    logic [CODE_W-1:0] w;
    exp_t e;
    int out0;

    total = 0; bad = 0; n_out = 0; m_corr = 0; m_dup = 0;
    stall_left = 0; rnd_ready = 1'b0; saw_block = 1'b0;
    rst = 1'b1; entrada = '0; entrada_valid = 1'b0; saida_ready = 1'b1; limpa_cnt = 1'b0;

    #12;
    chk("rst_saida_valid", saida_valid, 0);
    chk("rst_saida", saida, 0);
    chk("rst_flags", {erro_corrigido, erro_duplo}, 0);
    chk("rst_sindrome", sindrome, 0);
    chk("rst_cnts", {cnt_corrigido, cnt_duplo}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    saida_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", entrada_ready, 1);
    @(posedge clk);
    #1 saida_ready = 1'b1;

    // All-ones clean word, latency of exactly two cycles.
    w = '1;
    send(w, '{dado: 11'h7FF, corr: 1'b0, duplo: 1'b0, sind: 4'd0});
    cyc();
    chk("latency_not_early", last_sv, 0);
    cyc();
    chk("latency_two", last_sv, 1);
    cyc();

    // Single error at position 3.
    w = '1;
    w[2] = 1'b0;
    send(w, '{dado: 11'h7FF, corr: 1'b1, duplo: 1'b0, sind: 4'd3});
    drain();
    cyc();
    chk("cnt_corrigido_one", cnt_corrigido, 1);

    // Positions 1 and 2 set: double error with SECDED, miscorrection of position 3 without.
    w = CODE_W'(3);
    if (SECDED) send(w, '{dado: 11'h000, corr: 1'b0, duplo: 1'b1, sind: 4'd3});
    else        send(w, '{dado: 11'h001, corr: 1'b1, duplo: 1'b0, sind: 4'd3});
    drain();
    cyc();
    chk("cnt_duplo_after_double", cnt_duplo, SECDED ? 1 : 0);

    // Three words back-to-back into a stalled output.
    saida_ready = 1'b0;
    stall_left  = 3;
    saw_block   = 1'b0;
    out0        = n_out;
    for (int i = 0; i < 3; i++) begin
      rand_word(0, w, e);
      send(w, e);
    end
    chk("ready_dropped_when_full", saw_block, 1);
    drain();
    chk("three_words_out", n_out - out0, 3);

    // Reset with words in flight: they must vanish.
    rand_word(1, w, e);
    send(w, e);
    rand_word(0, w, e);
    send(w, e);
    rst = 1'b1;
    #2;
    chk("midrst_saida_valid", saida_valid, 0);
    chk("midrst_outputs", {saida, erro_corrigido, erro_duplo, sindrome}, 0);
    chk("midrst_cnts", {cnt_corrigido, cnt_duplo}, 0);
    cyc();
    rst = 1'b0;
    saida_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_midrst", entrada_ready, 1);
    @(posedge clk);
    #1 saida_ready = 1'b1;
    out0 = n_out;
    repeat (5) cyc();
    chk("no_ghost_word", n_out - out0, 0);

    // Saturation at 15 then clear coincident with the 21st accepted word.
    limpa_cnt = 1'b1;
    cyc();
    limpa_cnt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rand_word(1, w, e);
      send(w, e);
    end
    drain();
    cyc();
    chk("cnt_saturated", cnt_corrigido, 15);
    rand_word(1, w, e);
    send(w, e);
    cyc();
    limpa_cnt = 1'b1;
    cyc();
    limpa_cnt = 1'b0;
    chk("limpa_with_fire", last_out_fire, 1);
    chk("cnt_after_limpa", cnt_corrigido, 0);

    // Randomized traffic with gaps and random backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) cyc();
      rand_word(SECDED ? $urandom_range(0, 2) : $urandom_range(0, 1), w, e);
      send(w, e);
    end
    rnd_ready = 1'b0;
    drain();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
